// File: rtl/store_commit_buffer.sv
// Two-stage store buffer: speculative queue -> commit queue -> single-outstanding D$ write.
// Optional STORE_BUFFER_OFFSET_CHECK_EN builds exact [11:3] page-offset alias comparators.
module store_commit_buffer #(
  parameter int DEPTH_SPEC   = 4,
  parameter int DEPTH_COMMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] paddr_i,
  input  logic [63:0] data_i,
  input  logic [7:0]  be_i,
  input  logic [1:0]  data_size_i,
  input  logic        commit_i,
  output logic        commit_ready_o,
  output logic        no_st_pending_o,
  input  logic [11:0] page_offset_i,
  output logic        page_offset_matches_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_ack_i,
  output logic [63:0] mem_paddr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_be_o,
  output logic [1:0]  mem_size_o
);
  localparam int SPW = $clog2(DEPTH_SPEC);
  localparam int CPW = $clog2(DEPTH_COMMIT);
  localparam logic [SPW:0] SPEC_FULL   = (SPW+1)'(DEPTH_SPEC);
  localparam logic [SPW:0] SPEC_ZERO   = {(SPW+1){1'b0}};
  localparam logic [CPW:0] COMMIT_FULL = (CPW+1)'(DEPTH_COMMIT);
  localparam logic [CPW:0] COMMIT_ZERO = {(CPW+1){1'b0}};

  typedef struct packed {
    logic [63:0] pa;
    logic [63:0] dat;
    logic [7:0]  be;
    logic [1:0]  sz;
  } entry_t;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  entry_t         spec_mem_r   [DEPTH_SPEC];
  entry_t         commit_mem_r [DEPTH_COMMIT];
  logic [SPW-1:0] spec_rd_r, spec_wr_r, spec_rd_nxt_s;
  logic [SPW:0]   spec_cnt_r;
  logic [CPW-1:0] commit_rd_r, commit_wr_r;
  logic [CPW:0]   commit_cnt_r;
  state_t         state_r;
  entry_t         spec_head_s, commit_head_s;
  logic           spec_push_s, do_commit_s, mem_pop_s;
  logic           unused_s;

  assign spec_head_s    = spec_mem_r[spec_rd_r];
  assign commit_head_s  = commit_mem_r[commit_rd_r];
  assign ready_o        = spec_cnt_r < SPEC_FULL;
  assign commit_ready_o = commit_cnt_r < COMMIT_FULL;
  assign mem_req_o      = (state_r == S_IDLE) & (commit_cnt_r != COMMIT_ZERO);
  assign no_st_pending_o = (spec_cnt_r == SPEC_ZERO) & (commit_cnt_r == COMMIT_ZERO) &
                           (state_r == S_IDLE);

  // Flush kills a same-cycle push; a same-cycle commit still takes the head first.
  assign spec_push_s   = valid_i & ready_o & ~flush_i;
  assign do_commit_s   = commit_i & (spec_cnt_r != SPEC_ZERO) & commit_ready_o;
  assign mem_pop_s     = mem_req_o & mem_gnt_i;
  assign spec_rd_nxt_s = spec_rd_r + SPW'(do_commit_s);

  assign mem_paddr_o = commit_head_s.pa;
  assign mem_wdata_o = commit_head_s.dat;
  assign mem_be_o    = commit_head_s.be;
  assign mem_size_o  = commit_head_s.sz;

  // Entry storage for both queues; only the pointers/counts define validity.
  always_ff @(posedge clk_i) begin
    if (spec_push_s) begin
      spec_mem_r[spec_wr_r] <= '{pa: paddr_i, dat: data_i, be: be_i, sz: data_size_i};
    end
    if (do_commit_s) begin
      commit_mem_r[commit_wr_r] <= spec_head_s;
    end
  end

  // Speculative queue pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_rd_r  <= {SPW{1'b0}};
      spec_wr_r  <= {SPW{1'b0}};
      spec_cnt_r <= SPEC_ZERO;
    end else if (flush_i) begin
      spec_rd_r  <= spec_rd_nxt_s;
      spec_wr_r  <= spec_rd_nxt_s;
      spec_cnt_r <= SPEC_ZERO;
    end else begin
      spec_rd_r  <= spec_rd_nxt_s;
      spec_wr_r  <= spec_wr_r + SPW'(spec_push_s);
      spec_cnt_r <= spec_cnt_r + (SPW+1)'(spec_push_s) - (SPW+1)'(do_commit_s);
    end
  end

  // Commit queue pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      commit_rd_r  <= {CPW{1'b0}};
      commit_wr_r  <= {CPW{1'b0}};
      commit_cnt_r <= COMMIT_ZERO;
    end else begin
      commit_rd_r  <= commit_rd_r + CPW'(mem_pop_s);
      commit_wr_r  <= commit_wr_r + CPW'(do_commit_s);
      commit_cnt_r <= commit_cnt_r + (CPW+1)'(do_commit_s) - (CPW+1)'(mem_pop_s);
    end
  end

`ifdef STORE_BUFFER_OFFSET_CHECK_EN
  logic [8:0] inflight_off_r;
  logic       match_s;
`endif

  // Drain FSM: one D$ write outstanding between grant and ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_IDLE;
`ifdef STORE_BUFFER_OFFSET_CHECK_EN
      inflight_off_r <= 9'h000;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (mem_pop_s) begin
            state_r <= S_WAIT;
`ifdef STORE_BUFFER_OFFSET_CHECK_EN
            inflight_off_r <= commit_head_s.pa[11:3];
`endif
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

`ifdef STORE_BUFFER_OFFSET_CHECK_EN
  // Alias check: an entry is live when its distance from the read pointer is below the count.
  always_comb begin
    match_s = 1'b0;
    for (int i = 0; i < DEPTH_SPEC; i++) begin
      match_s = match_s |
                (({1'b0, SPW'(SPW'(i) - spec_rd_r)} < spec_cnt_r) &
                 (spec_mem_r[i].pa[11:3] == page_offset_i[11:3]));
    end
    for (int j = 0; j < DEPTH_COMMIT; j++) begin
      match_s = match_s |
                (({1'b0, CPW'(CPW'(j) - commit_rd_r)} < commit_cnt_r) &
                 (commit_mem_r[j].pa[11:3] == page_offset_i[11:3]));
    end
    match_s = match_s | ((state_r == S_WAIT) & (inflight_off_r == page_offset_i[11:3]));
  end

  assign page_offset_matches_o = match_s;
  assign unused_s = ^page_offset_i[2:0];
`else
  assign page_offset_matches_o = ~no_st_pending_o;
  assign unused_s = ^page_offset_i;
`endif
endmodule

// File: tb/tb_store_commit_buffer.sv
// Randomized + directed bench for store_commit_buffer with a queue-based reference model
// and a scoreboard of expected D$ writes checked whenever a request is granted.
module tb_store_commit_buffer;
  localparam int DS = 4;
  localparam int DC = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0, valid_i = 1'b0, commit_i = 1'b0;
  logic        mem_gnt_i = 1'b0, mem_ack_i = 1'b0;
  logic [63:0] paddr_i = 64'h0, data_i = 64'h0;
  logic [7:0]  be_i = 8'h00;
  logic [1:0]  data_size_i = 2'b00;
  logic [11:0] page_offset_i = 12'h000;
  logic        ready_o, commit_ready_o, no_st_pending_o, page_offset_matches_o, mem_req_o;
  logic [63:0] mem_paddr_o, mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic [1:0]  mem_size_o;

  always #5 clk = ~clk;

  store_commit_buffer #(.DEPTH_SPEC(DS), .DEPTH_COMMIT(DC)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i), .data_size_i(data_size_i),
    .commit_i(commit_i), .commit_ready_o(commit_ready_o), .no_st_pending_o(no_st_pending_o),
    .page_offset_i(page_offset_i), .page_offset_matches_o(page_offset_matches_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_ack_i(mem_ack_i),
    .mem_paddr_o(mem_paddr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_size_o(mem_size_o)
  );

  typedef struct packed {
    logic [63:0] pa;
    logic [63:0] dat;
    logic [7:0]  be;
    logic [1:0]  sz;
  } ent_t;

  ent_t spec_q[$], commit_q[$], exp_q[$];
  ent_t inflight;
  bit   busy = 1'b0;
  bit   run = 1'b0;
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_nsp();
    return spec_q.size() == 0 && commit_q.size() == 0 && !busy;
  endfunction

`ifdef STORE_BUFFER_OFFSET_CHECK_EN
  function automatic bit m_hit(input logic [11:0] po);
    ent_t e;
    for (int i = 0; i < spec_q.size(); i++) begin
      e = spec_q[i];
      if (e.pa[11:3] == po[11:3]) return 1'b1;
    end
    for (int i = 0; i < commit_q.size(); i++) begin
      e = commit_q[i];
      if (e.pa[11:3] == po[11:3]) return 1'b1;
    end
    return busy && (inflight.pa[11:3] == po[11:3]);
  endfunction
  localparam bit EXP_A50 = 1'b0;
`else
  localparam bit EXP_A50 = 1'b1;
`endif

  task automatic model_reset();
    spec_q.delete();
    commit_q.delete();
    exp_q.delete();
    busy = 1'b0;
  endtask

  // Reference model: applies one clock's worth of the queue rules.
  bit   a_commit, a_push, a_gnt, a_ack;
  ent_t m_e;
  always @(posedge clk) begin
    if (rst_ni) begin
      a_gnt    = !busy && commit_q.size() > 0 && mem_gnt_i;
      a_ack    = busy && mem_ack_i;
      a_commit = commit_i && spec_q.size() > 0 && commit_q.size() < DC;
      a_push   = valid_i && spec_q.size() < DS && !flush_i;
      if (a_gnt) begin
        inflight = commit_q.pop_front();
        busy = 1'b1;
      end else if (a_ack) begin
        busy = 1'b0;
      end
      if (a_commit) begin
        m_e = spec_q.pop_front();
        commit_q.push_back(m_e);
        exp_q.push_back(m_e);
      end
      if (flush_i) spec_q.delete();
      if (a_push) spec_q.push_back('{pa: paddr_i, dat: data_i, be: be_i, sz: data_size_i});
    end
  end

  // Monitor: status outputs every cycle, scoreboard pop on each granted request.
  bit   exp_match;
  ent_t s_e;
  always @(negedge clk) begin
    if (rst_ni && run) begin
`ifdef STORE_BUFFER_OFFSET_CHECK_EN
      exp_match = m_hit(page_offset_i);
`else
      exp_match = !m_nsp();
`endif
      chk("ready_o", 64'(ready_o), 64'(spec_q.size() < DS));
      chk("commit_ready_o", 64'(commit_ready_o), 64'(commit_q.size() < DC));
      chk("no_st_pending_o", 64'(no_st_pending_o), 64'(m_nsp()));
      chk("mem_req_o", 64'(mem_req_o), 64'(!busy && commit_q.size() > 0));
      chk("page_offset_matches_o", 64'(page_offset_matches_o), 64'(exp_match));
      if (mem_req_o && mem_gnt_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_req: got paddr %h expected no request", mem_paddr_o);
        end else begin
          s_e = exp_q.pop_front();
          chk("mem_paddr_o", mem_paddr_o, s_e.pa);
          chk("mem_wdata_o", mem_wdata_o, s_e.dat);
          chk("mem_be_o", 64'(mem_be_o), 64'(s_e.be));
          chk("mem_size_o", 64'(mem_size_o), 64'(s_e.sz));
        end
      end
    end
  end

  function automatic logic [8:0] pick_off();
    case ($urandom_range(0, 3))
      0: return 9'h040;
      1: return 9'h041;
      2: return 9'h149;
      default: return 9'h0AA;
    endcase
  endfunction

  function automatic logic [63:0] rnd_addr();
    return {$urandom(), 20'($urandom()), pick_off(), 3'b000};
  endfunction

  task automatic step(input bit v, input bit c, input bit fl, input bit g, input bit a,
                      input logic [63:0] pa);
    valid_i = v; commit_i = c; flush_i = fl; mem_gnt_i = g; mem_ack_i = a;
    paddr_i = pa;
    data_i = {$urandom(), $urandom()};
    be_i = 8'($urandom());
    data_size_i = 2'($urandom());
    page_offset_i = {pick_off(), 3'($urandom())};
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    model_reset();
    #1;
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_commit_ready_o", 64'(commit_ready_o), 64'd1);
    chk("rst_no_st_pending_o", 64'(no_st_pending_o), 64'd1);
    chk("rst_mem_req_o", 64'(mem_req_o), 64'd0);
    chk("rst_page_offset_matches_o", 64'(page_offset_matches_o), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
    run = 1'b1;

    // Fill speculative queue; fifth push dropped
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h1000 + 64'(8 * i));
    chk("spec_full_ready", 64'(ready_o), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h1020);
    chk("spec_drop_ready", 64'(ready_o), 64'd0);

    // Commit all four, then drain: gnt one cycle after req, ack two cycles after gnt
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    end
    chk("drain4_nsp", 64'(no_st_pending_o), 64'd1);

    // Commit and flush in the same cycle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h1000 + 64'(8 * i));
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("flush_ready", 64'(ready_o), 64'd1);
    chk("flush_paddr_head", mem_paddr_o, 64'h1000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    chk("flush_drain_nsp", 64'(no_st_pending_o), 64'd1);

    // In-flight page-offset hazard
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h2A48);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    page_offset_i = 12'hA4C;
    #1 chk("inflight_match", 64'(page_offset_matches_o), 64'd1);
    page_offset_i = 12'hA50;
    #1 chk("inflight_nomatch", 64'(page_offset_matches_o), 64'(EXP_A50));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);

    // Fill commit queue to 8 with no grants; extra commit ignored
    for (int i = 0; i < DC; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_addr());
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    end
    chk("commit_full", 64'(commit_ready_o), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_addr());
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_addr());
    chk("spec_head_retained", 64'(ready_o), 64'd0);

    // Reset during WAIT with entries queued; late ack ignored
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    #2 rst_ni = 1'b0;
    model_reset();
    #1;
    chk("midrst_nsp", 64'(no_st_pending_o), 64'd1);
    chk("midrst_mem_req", 64'(mem_req_o), 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk("midrst_commit_ready", 64'(commit_ready_o), 64'd1);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    chk("late_ack_mem_req", 64'(mem_req_o), 64'd0);
    chk("late_ack_nsp", 64'(no_st_pending_o), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr());
    end

    // Bounded drain of everything still pending
    n = 0;
    while (!m_nsp() && n < 400) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
      n++;
    end
    chk("final_nsp", 64'(no_st_pending_o), 64'd1);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
